// File: rtl/mu0_control_if.sv
// Control bundle between the MU0 fetch/execute controller and its datapath and memory port.
// master = controller side, slave = datapath/memory side.
interface mu0_control_if #(
    parameter int unsigned CNT_W = 16
);
    logic             run;
    logic [3:0]       f;
    logic             n;
    logic             z;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_wr;
    logic             addr_sel;
    logic             x_sel;
    logic             y_sel;
    logic [1:0]       m;
    logic             acc_en;
    logic             pc_en;
    logic             ir_en;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, f, n, z, mem_ack,
        output mem_req, mem_wr, addr_sel, x_sel, y_sel, m,
               acc_en, pc_en, ir_en, halted, fault, instr_count
    );

    modport slave (
        output run, f, n, z, mem_ack,
        input  mem_req, mem_wr, addr_sel, x_sel, y_sel, m,
               acc_en, pc_en, ir_en, halted, fault, instr_count
    );
endinterface

// File: rtl/mu0_control.sv
// MU0 fetch/execute controller: sequences memory via req/ack with a wait-state timeout,
// drives the ALU mode and datapath muxes/enables, and counts retired instructions.
module mu0_control #(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mu0_control_if.master bus
);
    localparam int unsigned WAIT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam int unsigned WAIT_LAST = (WAIT_MAX > 0) ? (WAIT_MAX - 1) : 0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_HALT  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    localparam logic [1:0] M_Y    = 2'b00;
    localparam logic [1:0] M_ADD  = 2'b01;
    localparam logic [1:0] M_INC  = 2'b10;
    localparam logic [1:0] M_SUB  = 2'b11;

    logic [2:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic       mem_req, mem_wr, addr_sel, x_sel, y_sel;
    logic [1:0] m;
    logic       acc_en, pc_en, ir_en, halted, fault;
    logic       retire;
    logic       timeout;
    logic       take_jump;
    logic [2:0] after_instr;

    // Request has sat unacknowledged for WAIT_MAX cycles once this cycle also goes unacked.
    assign timeout = (WAIT_MAX != 0) && (wait_cnt_q == WAIT_W'(WAIT_LAST));

    // Next state, control outputs and counter updates.
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_wr      = 1'b0;
        addr_sel    = 1'b0;
        x_sel       = 1'b0;
        y_sel       = 1'b0;
        m           = M_Y;
        acc_en      = 1'b0;
        pc_en       = 1'b0;
        ir_en       = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;
        retire      = 1'b0;
        take_jump   = 1'b0;
        after_instr = bus.run ? ST_FETCH : ST_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (bus.run) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ack) begin
                    ir_en   = 1'b1;
                    x_sel   = 1'b1;
                    m       = M_INC;
                    pc_en   = 1'b1;
                    state_d = ST_EXEC;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end

            ST_EXEC: begin
                case (bus.f)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
                        mem_req  = 1'b1;
                        addr_sel = 1'b1;
                        mem_wr   = (bus.f == OP_STA);
                        if (bus.mem_ack) begin
                            retire  = 1'b1;
                            state_d = after_instr;
                            if (bus.f != OP_STA) begin
                                acc_en = 1'b1;
                                m      = (bus.f == OP_ADD) ? M_ADD :
                                         (bus.f == OP_SUB) ? M_SUB : M_Y;
                            end
                        end else if (timeout) begin
                            state_d = ST_FAULT;
                        end
                    end

                    OP_JMP, OP_JGE, OP_JNE: begin
                        take_jump = (bus.f == OP_JMP) ||
                                    ((bus.f == OP_JGE) && !bus.n) ||
                                    ((bus.f == OP_JNE) && !bus.z);
                        if (take_jump) begin
                            y_sel = 1'b1;
                            m     = M_Y;
                            pc_en = 1'b1;
                        end
                        retire  = 1'b1;
                        state_d = after_instr;
                    end

                    OP_STP: begin
                        retire  = 1'b1;
                        state_d = ST_HALT;
                    end

                    default: begin
                        state_d = ST_FAULT;
                    end
                endcase
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            ST_FAULT: begin
                fault = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        count_d = retire ? (count_q + CNT_W'(1)) : count_q;

        // Wait counter only tracks the current unacknowledged request.
        if ((state_d != state_q) || bus.mem_ack) begin
            wait_cnt_d = '0;
        end else if (mem_req) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            count_q    <= count_d;
        end
    end

    assign bus.mem_req     = mem_req;
    assign bus.mem_wr      = mem_wr;
    assign bus.addr_sel    = addr_sel;
    assign bus.x_sel       = x_sel;
    assign bus.y_sel       = y_sel;
    assign bus.m           = m;
    assign bus.acc_en      = acc_en;
    assign bus.pc_en       = pc_en;
    assign bus.ir_en       = ir_en;
    assign bus.halted      = halted;
    assign bus.fault       = fault;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_mu0_control.sv
// Directed bench for mu0_control (WAIT_MAX=4, CNT_W=2) with hand-computed control vectors.
module tb_mu0_control;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mu0_control_if #(.CNT_W(2)) bus ();

    mu0_control #(.WAIT_MAX(4), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {req, wr, addr_sel, x_sel, y_sel, m[1:0], acc_en, pc_en, ir_en, halted, fault}
    logic [11:0] ctl;
    assign ctl = {bus.mem_req, bus.mem_wr, bus.addr_sel, bus.x_sel, bus.y_sel, bus.m,
                  bus.acc_en, bus.pc_en, bus.ir_en, bus.halted, bus.fault};

    localparam logic [11:0] MK_ALL = 12'b1_1_1_1_1_11_1_1_1_1_1;
    localparam logic [11:0] MK_NOX = 12'b1_1_1_0_1_11_1_1_1_1_1;
    localparam logic [11:0] MK_NOY = 12'b1_1_1_1_0_11_1_1_1_1_1;
    localparam logic [11:0] MK_HS  = 12'b1_1_1_0_0_00_1_1_1_1_1;

    localparam logic [11:0] V_QUIET   = 12'b0_0_0_0_0_00_0_0_0_0_0;
    localparam logic [11:0] V_F_ACK   = 12'b1_0_0_1_0_10_0_1_1_0_0;
    localparam logic [11:0] V_F_WAIT  = 12'b1_0_0_0_0_00_0_0_0_0_0;
    localparam logic [11:0] V_LDA_ACK = 12'b1_0_1_0_0_00_1_0_0_0_0;
    localparam logic [11:0] V_MEM_WT  = 12'b1_0_1_0_0_00_0_0_0_0_0;
    localparam logic [11:0] V_ADD_ACK = 12'b1_0_1_0_0_01_1_0_0_0_0;
    localparam logic [11:0] V_JMP     = 12'b0_0_0_0_1_00_0_1_0_0_0;
    localparam logic [11:0] V_STA     = 12'b1_1_1_0_0_00_0_0_0_0_0;
    localparam logic [11:0] V_HALT    = 12'b0_0_0_0_0_00_0_0_0_1_0;
    localparam logic [11:0] V_FAULT   = 12'b0_0_0_0_0_00_0_0_0_0_1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [11:0] exp, input logic [11:0] mask);
        check(tag, 16'(ctl & mask), 16'(exp & mask));
    endtask

    task automatic check_cnt(input string tag, input logic [1:0] exp);
        check(tag, 16'(bus.instr_count), 16'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; bus.run = 1'b0; bus.f = 4'd0; bus.n = 1'b0; bus.z = 1'b0; bus.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_ctl("reset_ctl", V_QUIET, MK_ALL);
        check_cnt("reset_cnt", 2'd0);
        rst_n = 1'b1;

        // LDA with ack every cycle
        bus.run = 1'b1; bus.mem_ack = 1'b1; bus.f = 4'd0; #1;
        check_ctl("idle_ctl", V_QUIET, MK_ALL);
        tick();
        check_ctl("lda_fetch", V_F_ACK, MK_NOY);
        tick();
        check_ctl("lda_exec", V_LDA_ACK, MK_NOX);
        tick();
        check_cnt("lda_cnt", 2'd1);
        check_ctl("lda_refetch", V_F_ACK, MK_NOY);

        // ADD with ack delayed 3 cycles; ack lands on the last cycle before timeout
        bus.f = 4'd2;
        tick();
        bus.mem_ack = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            check_ctl($sformatf("add_wait%0d", i), V_MEM_WT, MK_HS);
            tick();
        end
        bus.mem_ack = 1'b1; #1;
        check_ctl("add_ack", V_ADD_ACK, MK_ALL);
        tick();
        check_cnt("add_cnt", 2'd2);
        check_ctl("add_refetch", V_F_ACK, MK_NOY);

        // JGE not taken (N=1) then taken (N=0), single-cycle each
        bus.f = 4'd5; bus.n = 1'b1;
        tick();
        check_ctl("jge_nt", V_QUIET, MK_HS);
        tick();
        check_cnt("jge_nt_cnt", 2'd3);
        check_ctl("jge_nt_refetch", V_F_ACK, MK_NOY);
        bus.n = 1'b0;
        tick();
        check_ctl("jge_t", V_JMP, MK_NOX);
        tick();
        check_cnt("jge_t_cnt_wrap", 2'd0);

        // JNE not taken: fifth instruction with CNT_W=2 leaves count at 1
        bus.f = 4'd6; bus.z = 1'b1;
        tick();
        check_ctl("jne_nt", V_QUIET, MK_HS);
        tick();
        check_cnt("five_instr_cnt", 2'd1);

        // STA with Run dropped during the wait: write completes, then IDLE
        bus.f = 4'd1;
        tick();
        bus.mem_ack = 1'b0; bus.run = 1'b0; #1;
        check_ctl("sta_wait", V_STA, MK_HS);
        tick();
        bus.mem_ack = 1'b1; #1;
        check_ctl("sta_ack", V_STA, MK_HS);
        tick();
        check_ctl("sta_idle", V_QUIET, MK_ALL);
        check_cnt("sta_cnt", 2'd2);

        // STP: counts, then HALT holds regardless of inputs
        bus.run = 1'b1; bus.f = 4'd7;
        tick();
        tick();
        check_ctl("stp_exec", V_QUIET, MK_HS);
        tick();
        check_ctl("halt_ctl", V_HALT, MK_ALL);
        check_cnt("halt_cnt", 2'd3);
        repeat (3) tick();
        check_ctl("halt_hold", V_HALT, MK_ALL);
        check_cnt("halt_hold_cnt", 2'd3);

        // Reset leaves HALT; async reset mid-fetch drops the request immediately
        rst_n = 1'b0; #1;
        check_ctl("halt_reset_ctl", V_QUIET, MK_ALL);
        check_cnt("halt_reset_cnt", 2'd0);
        rst_n = 1'b1; bus.mem_ack = 1'b0;
        tick();
        check_ctl("pre_reset_fetch", V_F_WAIT, MK_HS);
        #2 rst_n = 1'b0; #1;
        check_ctl("async_reset_ctl", V_QUIET, MK_ALL);
        tick();

        // Illegal opcode after one LDA: FAULT, count unchanged
        rst_n = 1'b1; bus.mem_ack = 1'b1; bus.f = 4'd0;
        tick();
        tick();
        tick();
        check_cnt("pre_illegal_cnt", 2'd1);
        bus.f = 4'd9;
        tick();
        check_ctl("illegal_exec", V_QUIET, MK_HS);
        tick();
        check_ctl("illegal_fault", V_FAULT, MK_ALL);
        check_cnt("illegal_cnt", 2'd1);

        // Fetch timeout: 4 unacked request cycles, then FAULT until reset
        rst_n = 1'b0; #1;
        rst_n = 1'b1; bus.mem_ack = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_ctl($sformatf("to_wait%0d", i), V_F_WAIT, MK_HS);
            tick();
        end
        check_ctl("to_fault", V_FAULT, MK_ALL);
        bus.mem_ack = 1'b1;
        repeat (3) tick();
        check_ctl("to_fault_hold", V_FAULT, MK_ALL);
        check_cnt("to_cnt", 2'd0);
        rst_n = 1'b0; #1;
        check_ctl("to_reset", V_QUIET, MK_ALL);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
